tdm_demux_1to4: RTL and testbench

Time-division demultiplexer that reverses a 4:1 multiplexed serial stream. A source rotates a 4:1 mux select across four channels and sends one bit per beat, with channel A first. This block tracks the slot, steers each bit into the matching channel's shift register, and presents four parallel WIDTH-bit words once a full word per channel has been collected. It sits at the receiving end of the muxed link, in front of per-channel consumers.

---
 rtl/tdm_demux_1to4.sv | 117 +++++++++++
 tb/tb_tdm_demux_1to4.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: receives a 4:1 time-division multiplexed serial stream (slot 0 = channel A)
// and rebuilds four parallel WIDTH-bit words, MSB first.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   din         serial muxed data bit
//   din_valid   din carries a beat this cycle
//   frame_sync  marks a valid beat as slot 0 (channel A)
//   sel         slot the next valid beat is steered to (0=A .. 3=D)
//   out_a..d    last completed word per channel
//   out_valid   one-cycle pulse, out_a..out_d were just updated
//   locked      slot alignment established
//   sync_err    one-cycle pulse, frame_sync arrived at a non-zero slot
module tdm_demux_1to4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             out_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q [4];
  logic [WIDTH-1:0] sh_d [4];
  logic [WIDTH-1:0] word_q [4];
  logic [WIDTH-1:0] word_d [4];
  logic             out_valid_q, out_valid_d;
  logic             sync_err_q, sync_err_d;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    word_d      = word_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;

    if (din_valid) begin
      if (state_q == StHunt || (frame_sync && sel_q != 2'd0)) begin
        // Hunting, or a resync: only a framed beat matters, and it restarts slot 0 bit 0.
        if (frame_sync) begin
          sync_err_d = (state_q == StLocked);
          for (int i = 0; i < 4; i++) sh_d[i] = '0;
          sh_d[0] = {{(WIDTH-1){1'b0}}, din};
          cnt_d   = '0;
          sel_d   = 2'd1;
          state_d = StLocked;
        end
      end else begin
        sh_d[sel_q] = {sh_q[sel_q][WIDTH-2:0], din};
        sel_d       = sel_q + 2'd1;  // wraps 3 -> 0
        if (sel_q == 2'd3) begin
          if (cnt_q == CntW'(WIDTH - 1)) begin
            // Word set complete; old shift contents get fully overwritten by the next word.
            word_d      = sh_d;
            out_valid_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      sel_q       <= 2'd0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh_q[i]   <= '0;
        word_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      for (int i = 0; i < 4; i++) begin
        sh_q[i]   <= sh_d[i];
        word_q[i] <= word_d[i];
      end
    end
  end

  assign sel       = sel_q;
  assign out_a     = word_q[0];
  assign out_b     = word_q[1];
  assign out_c     = word_q[2];
  assign out_d     = word_q[3];
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign locked    = (state_q == StLocked);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Testbench for tdm_demux_1to4: vector table, directed word-set sequences and random beats,
// all checked against a frame-level reference model (bits collected per frame, words extracted
// by position).
module tb_tdm_demux_1to4;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [1:0]   sel;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic         out_valid, locked, sync_err;

  always #5 clk = ~clk;

  tdm_demux_1to4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .sel        (sel),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_c      (out_c),
    .out_d      (out_d),
    .out_valid  (out_valid),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int last_valid_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the beats of the current frame in arrival order.
  bit           m_locked;
  bit           m_frame[$];
  logic [W-1:0] m_out[4];
  bit           m_valid, m_err;

  typedef struct {
    bit         v;
    bit         fs;
    bit         d;
    logic [1:0] sel;
    bit         lk;
    bit         err;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_frame.delete();
    for (int c = 0; c < 4; c++) m_out[c] = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit fs, input bit d);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (fs) begin
          m_locked = 1'b1;
          m_frame.delete();
          m_frame.push_back(d);
        end
      end else if (fs && (m_frame.size() % 4) != 0) begin
        m_err = 1'b1;
        m_frame.delete();
        m_frame.push_back(d);
      end else begin
        m_frame.push_back(d);
        if (m_frame.size() == 4 * W) begin
          // Beat 4*i+c is bit i (MSB first) of channel c.
          for (int c = 0; c < 4; c++) begin
            m_out[c] = '0;
            for (int i = 0; i < W; i++) m_out[c][W-1-i] = m_frame[4*i+c];
          end
          m_valid = 1'b1;
          m_frame.delete();
        end
      end
    end
  endtask

  task automatic beat(input bit v, input bit fs, input bit d);
    din_valid  = v;
    frame_sync = fs;
    din        = d;
    @(posedge clk);
    #1;
    model_step(v, fs, d);
    if (out_valid === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (sync_err === 1'b1) n_err++;
    chk("sel", 32'(sel), 32'(m_frame.size() % 4));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("out_a", 32'(out_a), 32'(m_out[0]));
    chk("out_b", 32'(out_b), 32'(m_out[1]));
    chk("out_c", 32'(out_c), 32'(m_out[2]));
    chk("out_d", 32'(out_d), 32'(m_out[3]));
  endtask

  task automatic send_set(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          input logic [W-1:0] d, input bit gap);
    logic [W-1:0] w[4];
    w[0] = a;
    w[1] = b;
    w[2] = c;
    w[3] = d;
    for (int k = 0; k < 4 * W; k++) begin
      beat(1'b1, k == 0, w[k%4][W-1-k/4]);
      if (gap) beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic chk_words(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    chk({name, "_a"}, 32'(out_a), 32'(a));
    chk({name, "_b"}, 32'(out_b), 32'(b));
    chk({name, "_c"}, 32'(out_c), 32'(c));
    chk({name, "_d"}, 32'(out_d), 32'(d));
  endtask

  // Reset asserted between clock edges; outputs must clear before any edge arrives.
  task automatic do_reset();
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    rst_n      = 1'b0;
    #2;
    chk("async_sel", 32'(sel), 32'd0);
    chk("async_locked", 32'(locked), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_sync_err", 32'(sync_err), 32'd0);
    chk_words("async", '0, '0, '0, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv0;
    int ne0;
    int p1;

    // v, fs, d -> expected sel, locked, sync_err after the edge
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sel", 32'(sel), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sync_err", 32'(sync_err), 32'd0);
    chk_words("reset", '0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      beat(tbl[i].v, tbl[i].fs, tbl[i].d);
      chk("tbl_sel", 32'(sel), 32'(tbl[i].sel));
      chk("tbl_locked", 32'(locked), 32'(tbl[i].lk));
      chk("tbl_sync_err", 32'(sync_err), 32'(tbl[i].err));
      chk("tbl_out_valid", 32'(out_valid), 32'd0);
    end

    // Lock and word
    do_reset();
    nv0 = n_valid;
    send_set(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0);
    chk("lock_pulse_now", 32'(out_valid), 32'd1);
    chk("lock_pulses", 32'(n_valid - nv0), 32'd1);
    chk_words("lock", 8'hA5, 8'h3C, 8'hFF, 8'h01);
    beat(1'b0, 1'b0, 1'b0);
    chk("lock_pulse_once", 32'(out_valid), 32'd0);

    // Hunt discard
    do_reset();
    for (int i = 0; i < 7; i++) begin
      beat(1'b1, 1'b0, 1'b1);
      chk("hunt_sel", 32'(sel), 32'd0);
      chk("hunt_locked", 32'(locked), 32'd0);
    end
    nv0 = n_valid;
    send_set(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0);
    chk("hunt_pulses", 32'(n_valid - nv0), 32'd1);
    chk_words("hunt", 8'hA5, 8'h3C, 8'hFF, 8'h01);

    // Gapped valid
    nv0 = n_valid;
    ne0 = n_err;
    send_set(8'h5A, 8'hC3, 8'h0F, 8'h80, 1'b1);
    chk("gap_pulses", 32'(n_valid - nv0), 32'd1);
    chk("gap_errs", 32'(n_err - ne0), 32'd0);
    chk_words("gap", 8'h5A, 8'hC3, 8'h0F, 8'h80);

    // Misaligned sync
    for (int i = 0; i < 10; i++) beat(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("mis_sel_before", 32'(sel), 32'd2);
    nv0 = n_valid;
    ne0 = n_err;
    send_set(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    chk("mis_errs", 32'(n_err - ne0), 32'd1);
    chk("mis_pulses", 32'(n_valid - nv0), 32'd1);
    chk_words("mis", 8'h12, 8'h34, 8'h56, 8'h78);

    // Back-to-back plus reset
    nv0 = n_valid;
    send_set(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    chk_words("b2b1", 8'h11, 8'h22, 8'h33, 8'h44);
    p1 = last_valid_cyc;
    send_set(8'hEE, 8'hDD, 8'hCC, 8'hBB, 1'b0);
    chk_words("b2b2", 8'hEE, 8'hDD, 8'hCC, 8'hBB);
    chk("b2b_pulses", 32'(n_valid - nv0), 32'd2);
    chk("b2b_spacing", 32'(last_valid_cyc - p1), 32'd32);
    beat(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) beat(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    do_reset();
    nv0 = n_valid;
    for (int i = 0; i < 40; i++) beat(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("rst_no_pulse", 32'(n_valid - nv0), 32'd0);
    chk("rst_unlocked", 32'(locked), 32'd0);
    send_set(8'h69, 8'h96, 8'hF0, 8'h0F, 1'b0);
    chk("rst_relock_pulses", 32'(n_valid - nv0), 32'd1);
    chk_words("relock", 8'h69, 8'h96, 8'hF0, 8'h0F);

    // Random traffic with occasional misplaced frame_sync
    for (int i = 0; i < 3000; i++) begin
      beat(($urandom_range(0, 3) != 0), ($urandom_range(0, 47) == 0),
           1'($urandom_range(0, 1)));
    end
    repeat (3) beat(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
